regfile_mp: RTL

Parametrised multi-read-port register file for the single-cycle and next pipelined MIPS datapath. It has two write ports: an early ALU port and a late load/multi-cycle port. It also has:
- optional write-to-read bypass;
- a hardwired zero register;
- a per-register busy scoreboard, so decode can detect reads of registers whose late writeback is still pending.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/regfile_if.sv | 39 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 95 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  // Upper bounds that size the generic helper arguments.
  localparam int unsigned MAX_ADDR_W = 8;
  localparam int unsigned MAX_NUM_RD = 4;
  localparam int unsigned MAX_DEPTH  = 2 ** MAX_ADDR_W;
  localparam int unsigned RDV_W      = MAX_NUM_RD * MAX_ADDR_W;

  // Number of set bits in a (zero-extended) busy vector.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [MAX_DEPTH-1:0] v;
    int unsigned          cnt;
    v   = vec;
    cnt = 0;
    for (int unsigned b = 0; b < MAX_DEPTH; b++) begin
      cnt = cnt + 32'(v[0]);
      v   = v >> 1;
    end
    return cnt;
  endfunction

  // Extract read address idx (aw bits wide) from a packed address vector.
  function automatic logic [MAX_ADDR_W-1:0] addr_slice(input logic [RDV_W-1:0] vec,
                                                       input int unsigned     idx,
                                                       input int unsigned     aw);
    logic [RDV_W-1:0]      sh;
    logic [MAX_ADDR_W-1:0] mask;
    sh   = vec >> (idx * aw);
    mask = ~({MAX_ADDR_W{1'b1}} << aw);
    return sh[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;

  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;

  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     clr;

  logic [ADDR_W:0]          busy_cnt;
  logic                     stall;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr,
    input  rd_data, rd_busy, busy_cnt, stall
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, clr,
    output rd_data, rd_busy, busy_cnt, stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending late writebacks, plus a registered count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  input  logic                   wr1_en_i,
  input  logic [ADDR_W-1:0]      wr1_addr_i,
  input  logic                   clr_i,
  output logic [(2**ADDR_W)-1:0] busy_o,
  output logic [ADDR_W:0]        busy_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] rsv_hot, cpl_hot;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next busy state: flush, else reservation set over completion clear.
  always_comb begin
    rsv_hot = rsv_en_i ? (DEPTH'(1) << rsv_addr_i) : '0;
    cpl_hot = wr1_en_i ? (DEPTH'(1) << wr1_addr_i) : '0;
    if (clr_i) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~cpl_hot) | rsv_hot;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    cnt_d = CNT_W'(popcount(MAX_DEPTH'(busy_d)));
  end

  // Busy bits and count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with early/late write ports, bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W:0]   busy_cnt;

  // Array write: late port first so the early port wins on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (bus.wr1_en) begin
      mem_d[bus.wr1_addr] = bus.wr1_data;
    end
    if (bus.wr0_en) begin
      mem_d[bus.wr0_addr] = bus.wr0_data;
    end
    if (ZERO_REG != 0) begin
      mem_d[0] = '0;
    end
  end

  // Data array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rsv_en_i  (bus.rsv_en),
    .rsv_addr_i(bus.rsv_addr),
    .wr1_en_i  (bus.wr1_en),
    .wr1_addr_i(bus.wr1_addr),
    .clr_i     (bus.clr),
    .busy_o    (busy),
    .busy_cnt_o(busy_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbusy;

    assign ra = ADDR_W'(addr_slice(RDV_W'(bus.rd_addr), i, ADDR_W));

    // Read mux: bypass from same-cycle writes, then zero-register gating.
    always_comb begin
      rdat  = mem_q[ra];
      rbusy = busy[ra];
      if (BYPASS != 0) begin
        if (bus.wr0_en && (bus.wr0_addr == ra)) begin
          rdat = bus.wr0_data;
        end else if (bus.wr1_en && (bus.wr1_addr == ra)) begin
          rdat = bus.wr1_data;
        end
        if (bus.wr1_en && (bus.wr1_addr == ra)) begin
          rbusy = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = rdat;
    assign bus.rd_busy[i]                  = rbusy;
  end

  assign bus.busy_cnt = busy_cnt;
  assign bus.stall    = |bus.rd_busy;

endmodule
